// File: rtl/eceg_cipher_ctrl.sv
// ---------------------------------------------------------------------------
// eceg_cipher_ctrl
//
// Sequencer for EC-ElGamal encryption / decryption on top of the UECA
// point-arithmetic unit. A request is captured in IDLE. The block then issues
// the point multiplications and the final point addition to UECA one after
// another, forwarding intermediate points between steps.
//
//   encrypt (op=0): C1 = k*G  -> r0
//                   S  = k*Q
//                   C2 = M + S -> r1
//   decrypt (op=1): S  = d*C1
//                   M  = C2 + (-S) -> r1, r0 = 0
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   start, op, scalar       request strobe (IDLE only), 0=enc/1=dec, k or d
//   pa_x/y, pb_x/y, in_x/y  request points (G/Q/M for enc, C1/-/C2 for dec)
//   busy, done, err         status; err: 0 ok, 1 zero scalar, 2 timeout
//   r0_x/y, r1_x/y          results, valid at done, held until next accept
//   u_enable, u_mode, u_k,
//   u_px/py, u_p2x/p2y      UECA command (mode 0 = add, 1 = multiply)
//   u_qx/qy, u_ready        UECA result and sticky completion flag
//   dbg_state               current FSM state for observation
// ---------------------------------------------------------------------------
`ifndef DATAWIDTH
`define DATAWIDTH 16
`endif
`ifndef P
`define P 23
`endif

module eceg_cipher_ctrl #(
    parameter int                   DATAWIDTH = `DATAWIDTH,
    parameter logic [23:0]          TIMEOUT   = 24'hFF_FFFF,
    parameter logic [DATAWIDTH-1:0] PRIME     = DATAWIDTH'(`P)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 op,
    input  logic [DATAWIDTH-1:0] scalar,
    input  logic [DATAWIDTH-1:0] pa_x,
    input  logic [DATAWIDTH-1:0] pa_y,
    input  logic [DATAWIDTH-1:0] pb_x,
    input  logic [DATAWIDTH-1:0] pb_y,
    input  logic [DATAWIDTH-1:0] in_x,
    input  logic [DATAWIDTH-1:0] in_y,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           err,
    output logic [DATAWIDTH-1:0] r0_x,
    output logic [DATAWIDTH-1:0] r0_y,
    output logic [DATAWIDTH-1:0] r1_x,
    output logic [DATAWIDTH-1:0] r1_y,
    output logic                 u_enable,
    output logic                 u_mode,
    output logic [DATAWIDTH-1:0] u_k,
    output logic [DATAWIDTH-1:0] u_px,
    output logic [DATAWIDTH-1:0] u_py,
    output logic [DATAWIDTH-1:0] u_p2x,
    output logic [DATAWIDTH-1:0] u_p2y,
    input  logic [DATAWIDTH-1:0] u_qx,
    input  logic [DATAWIDTH-1:0] u_qy,
    input  logic                 u_ready,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_MUL1_ISSUE = 3'd1,
        S_MUL1_WAIT  = 3'd2,
        S_MUL2_ISSUE = 3'd3,
        S_MUL2_WAIT  = 3'd4,
        S_ADD_ISSUE  = 3'd5,
        S_ADD_WAIT   = 3'd6,
        S_FIN        = 3'd7
    } state_t;

    state_t state, state_nxt;

    // Captured request
    logic                 op_q;
    logic [DATAWIDTH-1:0] k_q;
    logic [DATAWIDTH-1:0] pa_x_q, pa_y_q, pb_x_q, pb_y_q, in_x_q, in_y_q;

    // Intermediate point S (k*Q or d*C1)
    logic [DATAWIDTH-1:0] s_x, s_y;
    logic [DATAWIDTH-1:0] s_y_neg;

    logic [23:0] wdog;
    logic [23:0] wdog_inc;

    logic accept;   // request captured this cycle
    logic take;     // UECA result consumed this cycle
    logic tmo;      // watchdog expired this cycle
    logic in_wait;

    assign dbg_state = state;

    // -y mod P. S_y is always a reduced coordinate (< P), so P - S_y cannot
    // underflow; y = 0 maps to 0 rather than to P.
    assign s_y_neg = (s_y == '0) ? '0 : (PRIME - s_y);

    assign wdog_inc = wdog + 24'd1;

    // UECA handshake: u_enable is a one-cycle command strobe issued from an
    // *_ISSUE state; operands are valid in that cycle and stay constant for
    // the whole matching *_WAIT state. u_ready is a level that remains high
    // from the end of one operation until UECA accepts the next enable, so
    // during the first WAIT cycle it may still reflect the previous command
    // and is ignored there (the watchdog is 0 only in that cycle).
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        in_wait   = (state == S_MUL1_WAIT) || (state == S_MUL2_WAIT) ||
                    (state == S_ADD_WAIT);
        take      = in_wait && u_ready && (wdog != 24'd0);
        tmo       = in_wait && !take && (wdog_inc == TIMEOUT);
        busy      = 1'b0;
        done      = 1'b0;
        u_enable  = 1'b0;
        u_mode    = 1'b0;
        u_k       = '0;
        u_px      = '0;
        u_py      = '0;
        u_p2x     = '0;
        u_p2y     = '0;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    // UECA never terminates on a zero scalar: fail fast.
                    if (scalar == '0)
                        state_nxt = S_FIN;
                    else if (op)
                        state_nxt = S_MUL2_ISSUE;
                    else
                        state_nxt = S_MUL1_ISSUE;
                end
            end
            S_MUL1_ISSUE, S_MUL1_WAIT: begin
                busy     = 1'b1;
                u_enable = (state == S_MUL1_ISSUE);
                u_mode   = 1'b1;
                u_k      = k_q;
                u_px     = pa_x_q;
                u_py     = pa_y_q;
                if (state == S_MUL1_ISSUE)
                    state_nxt = S_MUL1_WAIT;
                else if (take)
                    state_nxt = S_MUL2_ISSUE;
                else if (tmo)
                    state_nxt = S_FIN;
            end
            S_MUL2_ISSUE, S_MUL2_WAIT: begin
                busy     = 1'b1;
                u_enable = (state == S_MUL2_ISSUE);
                u_mode   = 1'b1;
                u_k      = k_q;
                u_px     = op_q ? pa_x_q : pb_x_q;
                u_py     = op_q ? pa_y_q : pb_y_q;
                if (state == S_MUL2_ISSUE)
                    state_nxt = S_MUL2_WAIT;
                else if (take)
                    state_nxt = S_ADD_ISSUE;
                else if (tmo)
                    state_nxt = S_FIN;
            end
            S_ADD_ISSUE, S_ADD_WAIT: begin
                busy     = 1'b1;
                u_enable = (state == S_ADD_ISSUE);
                u_px     = in_x_q;
                u_py     = in_y_q;
                u_p2x    = s_x;
                u_p2y    = op_q ? s_y_neg : s_y;
                if (state == S_ADD_ISSUE)
                    state_nxt = S_ADD_WAIT;
                else if (take || tmo)
                    state_nxt = S_FIN;
            end
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= 1'b0;
            k_q    <= '0;
            pa_x_q <= '0;
            pa_y_q <= '0;
            pb_x_q <= '0;
            pb_y_q <= '0;
            in_x_q <= '0;
            in_y_q <= '0;
            s_x    <= '0;
            s_y    <= '0;
            r0_x   <= '0;
            r0_y   <= '0;
            r1_x   <= '0;
            r1_y   <= '0;
            err    <= 2'd0;
            wdog   <= 24'd0;
        end else begin
            if (accept) begin
                op_q   <= op;
                k_q    <= scalar;
                pa_x_q <= pa_x;
                pa_y_q <= pa_y;
                pb_x_q <= pb_x;
                pb_y_q <= pb_y;
                in_x_q <= in_x;
                in_y_q <= in_y;
                s_x    <= '0;
                s_y    <= '0;
                r0_x   <= '0;
                r0_y   <= '0;
                r1_x   <= '0;
                r1_y   <= '0;
                err    <= (scalar == '0) ? 2'd1 : 2'd0;
            end

            case (state)
                S_MUL1_ISSUE, S_MUL2_ISSUE, S_ADD_ISSUE: wdog <= 24'd0;
                S_MUL1_WAIT, S_MUL2_WAIT, S_ADD_WAIT:    wdog <= wdog_inc;
                default: ;
            endcase

            if (take) begin
                case (state)
                    S_MUL1_WAIT: begin
                        r0_x <= u_qx;
                        r0_y <= u_qy;
                    end
                    S_MUL2_WAIT: begin
                        s_x <= u_qx;
                        s_y <= u_qy;
                    end
                    S_ADD_WAIT: begin
                        r1_x <= u_qx;
                        r1_y <= u_qy;
                    end
                    default: ;
                endcase
            end

            if (tmo)
                err <= 2'd2;
        end
    end

endmodule

// File: tb/tb_eceg_cipher_ctrl.sv
// ---------------------------------------------------------------------------
// tb_eceg_cipher_ctrl
//
// Directed bench for eceg_cipher_ctrl with a behavioural UECA stub. The stub
// raises u_ready 10 edges after it samples u_enable, returning the next
// point from a per-test result table, and drops u_ready one edge late so
// the previous result is still flagged ready during the first WAIT cycle.
// Latencies are counted in negedges after the accept edge (1 = the cycle
// right after accept).
// ---------------------------------------------------------------------------
module tb_eceg_cipher_ctrl;

    localparam int          DW  = 16;
    localparam logic [23:0] TMO = 24'd50;
    localparam logic [15:0] PR  = 16'd23;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          start = 1'b0;
    logic          op = 1'b0;
    logic [DW-1:0] scalar = '0;
    logic [DW-1:0] pa_x = '0, pa_y = '0, pb_x = '0, pb_y = '0, in_x = '0, in_y = '0;
    logic          busy, done;
    logic [1:0]    err;
    logic [DW-1:0] r0_x, r0_y, r1_x, r1_y;
    logic          u_enable, u_mode;
    logic [DW-1:0] u_k, u_px, u_py, u_p2x, u_p2y;
    logic [DW-1:0] u_qx = '0, u_qy = '0;
    logic          u_ready = 1'b0;
    logic [2:0]    dbg_state;

    eceg_cipher_ctrl #(
        .DATAWIDTH(DW),
        .TIMEOUT  (TMO),
        .PRIME    (PR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .scalar   (scalar),
        .pa_x     (pa_x),
        .pa_y     (pa_y),
        .pb_x     (pb_x),
        .pb_y     (pb_y),
        .in_x     (in_x),
        .in_y     (in_y),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .r0_x     (r0_x),
        .r0_y     (r0_y),
        .r1_x     (r1_x),
        .r1_y     (r1_y),
        .u_enable (u_enable),
        .u_mode   (u_mode),
        .u_k      (u_k),
        .u_px     (u_px),
        .u_py     (u_py),
        .u_p2x    (u_p2x),
        .u_p2y    (u_p2y),
        .u_qx     (u_qx),
        .u_qy     (u_qy),
        .u_ready  (u_ready),
        .dbg_state(dbg_state)
    );

    // ---------------- UECA stub ----------------
    logic [DW-1:0] res_x [8];
    logic [DW-1:0] res_y [8];
    logic          log_mode [8];
    logic [DW-1:0] log_k [8];
    logic [DW-1:0] log_px [8];
    logic [DW-1:0] log_py [8];
    logic [DW-1:0] log_p2x [8];
    logic [DW-1:0] log_p2y [8];
    int            n_en = 0;
    int            test_base = 0;
    int            en_idx;
    int            st_cnt = 0;
    logic [2:0]    st_idx = '0;
    logic          st_clr = 1'b0;
    logic          st_hang = 1'b0;

    assign en_idx = n_en - test_base;

    always @(posedge clk) begin
        if (st_clr) begin
            u_ready <= 1'b0;
            st_clr  <= 1'b0;
        end
        if (u_enable) begin
            if (en_idx >= 0 && en_idx < 8) begin
                log_mode[en_idx[2:0]] <= u_mode;
                log_k[en_idx[2:0]]    <= u_k;
                log_px[en_idx[2:0]]   <= u_px;
                log_py[en_idx[2:0]]   <= u_py;
                log_p2x[en_idx[2:0]]  <= u_p2x;
                log_p2y[en_idx[2:0]]  <= u_p2y;
            end
            st_idx <= en_idx[2:0];
            st_cnt <= 10;
            st_clr <= 1'b1;
            n_en   <= n_en + 1;
        end else if (st_cnt > 0) begin
            st_cnt <= st_cnt - 1;
            if (st_cnt == 1 && !st_hang) begin
                u_ready <= 1'b1;
                u_qx    <= res_x[st_idx];
                u_qy    <= res_y[st_idx];
            end
        end
    end

    int n_done = 0;
    int done_base = 0;
    always @(negedge clk) begin
        if (done)
            n_done <= n_done + 1;
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Expected r0_x, r0_y, r1_x, r1_y are queued by the test, popped here.
    task automatic check_results(input string tag);
        check_val({tag, "_r0x"}, 32'(r0_x), exp_q.pop_front());
        check_val({tag, "_r0y"}, 32'(r0_y), exp_q.pop_front());
        check_val({tag, "_r1x"}, 32'(r1_x), exp_q.pop_front());
        check_val({tag, "_r1y"}, 32'(r1_y), exp_q.pop_front());
    endtask

    task automatic push_results(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] c, input logic [31:0] d);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
        exp_q.push_back(d);
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_res(input int i, input logic [DW-1:0] x, input logic [DW-1:0] y);
        res_x[i] = x;
        res_y[i] = y;
    endtask

    task automatic req(input logic o, input logic [DW-1:0] k,
                       input logic [DW-1:0] ax, input logic [DW-1:0] ay,
                       input logic [DW-1:0] bx, input logic [DW-1:0] by,
                       input logic [DW-1:0] mx, input logic [DW-1:0] my);
        @(negedge clk);
        test_base = n_en;
        done_base = n_done;
        op     = o;
        scalar = k;
        pa_x   = ax;
        pa_y   = ay;
        pb_x   = bx;
        pb_y   = by;
        in_x   = mx;
        in_y   = my;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int lat;

        for (int i = 0; i < 8; i++) begin
            res_x[i] = '0;
            res_y[i] = '0;
        end

        repeat (3) @(negedge clk);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_en", 32'(u_enable), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        check_val("rst_r0x", 32'(r0_x), 32'd0);
        check_val("rst_uk", 32'(u_k), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // T1: encrypt, k=3, G=(1,2), Q=(3,4), M=(5,6)
        set_res(0, 16'h11, 16'h12);
        set_res(1, 16'h21, 16'h22);
        set_res(2, 16'h31, 16'h32);
        req(1'b0, 16'd3, 16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6);
        check_val("t1_busy_after_accept", 32'(busy), 32'd1);
        check_val("t1_enable_after_accept", 32'(u_enable), 32'd1);
        wait_done(200, lat);
        check_val("t1_latency", 32'(lat), 32'd37);
        check_val("t1_busy_at_done", 32'(busy), 32'd0);
        check_val("t1_err", 32'(err), 32'd0);
        push_results(32'h11, 32'h12, 32'h31, 32'h32);
        check_results("t1");
        repeat (3) @(negedge clk);
        check_val("t1_enables", 32'(n_en - test_base), 32'd3);
        check_val("t1_dones", 32'(n_done - done_base), 32'd1);
        check_val("t1_mode0", 32'(log_mode[0]), 32'd1);
        check_val("t1_mode1", 32'(log_mode[1]), 32'd1);
        check_val("t1_mode2", 32'(log_mode[2]), 32'd0);
        check_val("t1_k0", 32'(log_k[0]), 32'd3);
        check_val("t1_px0", 32'(log_px[0]), 32'h1);
        check_val("t1_py0", 32'(log_py[0]), 32'h2);
        check_val("t1_p2x0", 32'(log_p2x[0]), 32'h0);
        check_val("t1_k1", 32'(log_k[1]), 32'd3);
        check_val("t1_px1", 32'(log_px[1]), 32'h3);
        check_val("t1_py1", 32'(log_py[1]), 32'h4);
        check_val("t1_k2", 32'(log_k[2]), 32'd0);
        check_val("t1_px2", 32'(log_px[2]), 32'h5);
        check_val("t1_py2", 32'(log_py[2]), 32'h6);
        check_val("t1_p2x2", 32'(log_p2x[2]), 32'h21);
        check_val("t1_p2y2", 32'(log_p2y[2]), 32'h22);

        // T2: decrypt, d=7, C1=(A,B), C2=(C,D); S=(5,7) so -S_y = 23-7 = 0x10
        set_res(0, 16'h05, 16'h07);
        set_res(1, 16'h41, 16'h42);
        req(1'b1, 16'd7, 16'hA, 16'hB, 16'h77, 16'h77, 16'hC, 16'hD);
        wait_done(200, lat);
        check_val("t2_latency", 32'(lat), 32'd25);
        check_val("t2_err", 32'(err), 32'd0);
        push_results(32'h0, 32'h0, 32'h41, 32'h42);
        check_results("t2");
        repeat (3) @(negedge clk);
        check_val("t2_enables", 32'(n_en - test_base), 32'd2);
        check_val("t2_mode0", 32'(log_mode[0]), 32'd1);
        check_val("t2_k0", 32'(log_k[0]), 32'd7);
        check_val("t2_px0", 32'(log_px[0]), 32'hA);
        check_val("t2_py0", 32'(log_py[0]), 32'hB);
        check_val("t2_mode1", 32'(log_mode[1]), 32'd0);
        check_val("t2_k1", 32'(log_k[1]), 32'd0);
        check_val("t2_px1", 32'(log_px[1]), 32'hC);
        check_val("t2_py1", 32'(log_py[1]), 32'hD);
        check_val("t2_p2x1", 32'(log_p2x[1]), 32'h05);
        check_val("t2_p2y1", 32'(log_p2y[1]), 32'h10);

        // T3: decrypt with S_y = 0, plus a start pulse mid-operation
        set_res(0, 16'h09, 16'h00);
        set_res(1, 16'h51, 16'h52);
        req(1'b1, 16'd4, 16'hA, 16'hB, 16'h0, 16'h0, 16'hC, 16'hD);
        repeat (5) @(negedge clk);
        op     = 1'b0;
        scalar = '0;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wait_done(200, lat);
        check_val("t3_done_seen", 32'(lat != 0), 32'd1);
        check_val("t3_err", 32'(err), 32'd0);
        push_results(32'h0, 32'h0, 32'h51, 32'h52);
        check_results("t3");
        repeat (3) @(negedge clk);
        check_val("t3_enables", 32'(n_en - test_base), 32'd2);
        check_val("t3_dones", 32'(n_done - done_base), 32'd1);
        check_val("t3_p2x1", 32'(log_p2x[1]), 32'h09);
        check_val("t3_p2y1", 32'(log_p2y[1]), 32'h00);

        // T4: zero scalar
        req(1'b0, 16'd0, 16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6);
        wait_done(20, lat);
        check_val("t4_latency", 32'(lat), 32'd1);
        check_val("t4_err", 32'(err), 32'd1);
        push_results(32'h0, 32'h0, 32'h0, 32'h0);
        check_results("t4");
        repeat (3) @(negedge clk);
        check_val("t4_enables", 32'(n_en - test_base), 32'd0);
        check_val("t4_dones", 32'(n_done - done_base), 32'd1);

        // T5: UECA never answers -> watchdog after 50 WAIT cycles
        st_hang = 1'b1;
        req(1'b0, 16'd5, 16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6);
        wait_done(200, lat);
        check_val("t5_latency", 32'(lat), 32'd52);
        check_val("t5_err", 32'(err), 32'd2);
        check_val("t5_busy_at_done", 32'(busy), 32'd0);
        push_results(32'h0, 32'h0, 32'h0, 32'h0);
        check_results("t5");
        repeat (3) @(negedge clk);
        check_val("t5_err_held", 32'(err), 32'd2);
        check_val("t5_busy_after", 32'(busy), 32'd0);
        check_val("t5_enables", 32'(n_en - test_base), 32'd1);
        st_hang = 1'b0;

        // T6: reset asserted while in MUL2_WAIT
        set_res(0, 16'h61, 16'h62);
        set_res(1, 16'h71, 16'h72);
        set_res(2, 16'h81, 16'h82);
        req(1'b0, 16'd9, 16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6);
        lat = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (n_en - test_base == 2) begin
                lat = c;
                break;
            end
        end
        check_val("t6_reached_mul2", 32'(lat != 0), 32'd1);
        repeat (3) @(negedge clk);
        check_val("t6_r0x_before_rst", 32'(r0_x), 32'h61);
        #2 rst_n = 1'b0;
        #1;
        check_val("t6_rst_busy", 32'(busy), 32'd0);
        check_val("t6_rst_en", 32'(u_enable), 32'd0);
        check_val("t6_rst_mode", 32'(u_mode), 32'd0);
        check_val("t6_rst_uk", 32'(u_k), 32'd0);
        check_val("t6_rst_upx", 32'(u_px), 32'd0);
        check_val("t6_rst_r0x", 32'(r0_x), 32'd0);
        check_val("t6_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);

        // T7: new encrypt after reset completes normally
        set_res(0, 16'h91, 16'h92);
        set_res(1, 16'hA1, 16'hA2);
        set_res(2, 16'hB1, 16'hB2);
        req(1'b0, 16'd2, 16'h7, 16'h8, 16'h9, 16'hA, 16'hB, 16'hC);
        wait_done(200, lat);
        check_val("t7_latency", 32'(lat), 32'd37);
        check_val("t7_err", 32'(err), 32'd0);
        push_results(32'h91, 32'h92, 32'hB1, 32'hB2);
        check_results("t7");
        repeat (3) @(negedge clk);
        check_val("t7_enables", 32'(n_en - test_base), 32'd3);
        check_val("t7_px0", 32'(log_px[0]), 32'h7);
        check_val("t7_px1", 32'(log_px[1]), 32'h9);
        check_val("t7_p2x2", 32'(log_p2x[2]), 32'hA1);
        check_val("t7_p2y2", 32'(log_p2y[2]), 32'hA2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
